// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - ALU result register stage with flags and 2-entry skid buffer
//
// Captures the function-select mux result together with its select code,
// derives zero/neg/carry/ovf flags at capture time, and presents entries
// through a 2-deep valid/ready skid buffer (main entry drives out_*).
//
// Ports:
//   clk, rst                     clock (rising edge), async active-high reset
//   in_valid / in_ready          upstream handshake (in_ready is registered)
//   in_result, in_sel            selected result and its function select
//   in_carry, in_ovf             adder carry-out and signed overflow
//   out_valid / out_ready        downstream handshake
//   out_result, out_sel          registered result and select
//   out_zero, out_neg            flags derived from the result
//   out_carry, out_ovf           arithmetic flags, 0 for non-arithmetic selects
//
// Optional feature macro ALU_RESULT_STAGE_STICKY_OVF_EN adds:
//   ovf_clr (in)                 clears the sticky overflow flag
//   ovf_sticky (out)             sets on any pop of an entry with ovf=1; set wins over clear
module alu_result_stage #(
   parameter int          WIDTH    = 32,
   parameter logic [3:0]  ADD_CODE = 4'h0,
   parameter logic [3:0]  SUB_CODE = 4'h1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_result,
   input  logic [3:0]       in_sel,
   input  logic             in_carry,
   input  logic             in_ovf,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic [3:0]       out_sel,
   output logic             out_zero,
   output logic             out_neg,
   output logic             out_carry,
`ifdef ALU_RESULT_STAGE_STICKY_OVF_EN
   input  logic             ovf_clr,
   output logic             ovf_sticky,
`endif
   output logic             out_ovf
);

   // Entry layout: {result, sel, zero, neg, carry, ovf}
   localparam int EW = WIDTH + 8;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [EW-1:0]   main_q, main_d;
   logic [EW-1:0]   skid_q, skid_d;
   logic            in_ready_q;
   logic [EW-1:0]   new_entry;
   logic            is_arith;
   logic            accept;
   logic            pop;

   always_comb begin
      is_arith  = (in_sel == ADD_CODE) || (in_sel == SUB_CODE);
      new_entry = {in_result, in_sel, ~|in_result, in_result[WIDTH-1],
                   in_carry & is_arith, in_ovf & is_arith};
      accept    = in_valid & in_ready_q;
      pop       = (state_q != EMPTY) & out_ready;

      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      unique case (state_q)
         EMPTY: begin
            if (accept) begin
               state_d = ONE;
               main_d  = new_entry;
            end
         end
         ONE: begin
            if (accept && !pop) begin
               state_d = TWO;
               skid_d  = new_entry;
            end else if (accept && pop) begin
               main_d  = new_entry;
            end else if (pop) begin
               state_d = EMPTY;
            end
         end
         TWO: begin
            // in_ready is low here, so no accept can coincide with the pop
            if (pop) begin
               state_d = ONE;
               main_d  = skid_q;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= EMPTY;
         main_q     <= '0;
         skid_q     <= '0;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         main_q     <= main_d;
         skid_q     <= skid_d;
         // Registered ready: drops the cycle after the second entry lands
         in_ready_q <= (state_d != TWO);
      end
   end

`ifdef ALU_RESULT_STAGE_STICKY_OVF_EN
   logic ovf_sticky_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_sticky_q <= 1'b0;
      end else if (pop && main_q[0]) begin
         ovf_sticky_q <= 1'b1;
      end else if (ovf_clr) begin
         ovf_sticky_q <= 1'b0;
      end
   end

   assign ovf_sticky = ovf_sticky_q;
`endif

   assign in_ready   = in_ready_q;
   assign out_valid  = (state_q != EMPTY);
   assign out_result = main_q[EW-1:8];
   assign out_sel    = main_q[7:4];
   assign out_zero   = main_q[3];
   assign out_neg    = main_q[2];
   assign out_carry  = main_q[1];
   assign out_ovf    = main_q[0];

endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - self-checking bench for alu_result_stage
module tb_alu_result_stage;

   localparam int WIDTH = 32;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_result;
   logic [3:0]       in_sel;
   logic             in_carry;
   logic             in_ovf;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_result;
   logic [3:0]       out_sel;
   logic             out_zero;
   logic             out_neg;
   logic             out_carry;
   logic             out_ovf;
`ifdef ALU_RESULT_STAGE_STICKY_OVF_EN
   logic             ovf_clr;
   logic             ovf_sticky;
`endif

   alu_result_stage #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_result  (in_result),
      .in_sel     (in_sel),
      .in_carry   (in_carry),
      .in_ovf     (in_ovf),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_sel    (out_sel),
      .out_zero   (out_zero),
      .out_neg    (out_neg),
      .out_carry  (out_carry),
`ifdef ALU_RESULT_STAGE_STICKY_OVF_EN
      .ovf_clr    (ovf_clr),
      .ovf_sticky (ovf_sticky),
`endif
      .out_ovf    (out_ovf)
   );

   always #5 clk = ~clk;

   // Reference model: a FIFO of raw accepted inputs, capacity two
   typedef struct {
      logic [WIDTH-1:0] result;
      logic [3:0]       sel;
      logic             carry;
      logic             ovf;
   } item_t;

   item_t q[$];
   logic  exp_ready;
   logic  exp_sticky;
   int    n_checks = 0;
   int    n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   task automatic compare_outputs();
      logic arith;
      check("out_valid", out_valid, q.size() > 0);
      check("in_ready", in_ready, exp_ready);
      if (q.size() > 0) begin
         arith = (q[0].sel == 4'h0) || (q[0].sel == 4'h1);
         check("out_result", out_result, q[0].result);
         check("out_sel", out_sel, q[0].sel);
         check("out_zero", out_zero, q[0].result == 0);
         check("out_neg", out_neg, q[0].result[WIDTH-1]);
         check("out_carry", out_carry, arith ? q[0].carry : 1'b0);
         check("out_ovf", out_ovf, arith ? q[0].ovf : 1'b0);
      end
`ifdef ALU_RESULT_STAGE_STICKY_OVF_EN
      check("ovf_sticky", ovf_sticky, exp_sticky);
`endif
   endtask

   // One clock: drive inputs, advance the model, sample #1 after the edge
   task automatic step(input logic v, input logic [WIDTH-1:0] r, input logic [3:0] s,
                       input logic c, input logic o, input logic rdy, input logic clr);
      logic  acc, pp, arith;
      item_t it;
      in_valid  = v;
      in_result = r;
      in_sel    = s;
      in_carry  = c;
      in_ovf    = o;
      out_ready = rdy;
`ifdef ALU_RESULT_STAGE_STICKY_OVF_EN
      ovf_clr   = clr;
`endif
      acc = v && exp_ready;
      pp  = (q.size() > 0) && rdy;
      if (pp) begin
         it    = q.pop_front();
         arith = (it.sel == 4'h0) || (it.sel == 4'h1);
         if (arith && it.ovf) exp_sticky = 1'b1;
         else if (clr) exp_sticky = 1'b0;
      end else if (clr) begin
         exp_sticky = 1'b0;
      end
      if (acc) begin
         it.result = r; it.sel = s; it.carry = c; it.ovf = o;
         q.push_back(it);
      end
      exp_ready = q.size() < 2;
      @(posedge clk);
      #1;
      compare_outputs();
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0; in_result = '0; in_sel = '0; in_carry = 1'b0; in_ovf = 1'b0;
      out_ready = 1'b0;
`ifdef ALU_RESULT_STAGE_STICKY_OVF_EN
      ovf_clr = 1'b0;
`endif
      exp_ready = 1'b1;
      exp_sticky = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", out_valid, 1'b0);
      check("rst_ready", in_ready, 1'b1);
      check("rst_result", out_result, 0);
      check("rst_flags", {out_sel, out_zero, out_neg, out_carry, out_ovf}, 0);
      rst = 1'b0;

      // Zero result with add select: zero and carry pass through
      step(1, 32'h0, 4'h0, 1, 0, 0, 0);
      check("t1_zero", out_zero, 1'b1);
      check("t1_carry", out_carry, 1'b1);
      step(0, 0, 0, 0, 0, 1, 0);

      // Non-arithmetic select masks carry/ovf
      step(1, 32'h8000_0001, 4'h5, 1, 1, 0, 0);
      check("t2_neg", out_neg, 1'b1);
      check("t2_mask", {out_carry, out_ovf}, 2'b00);
      step(0, 0, 0, 0, 0, 1, 0);

      // Back-pressure: 11, 22 captured, 33 held upstream until space frees
      step(1, 32'd11, 4'h2, 0, 0, 0, 0);
      step(1, 32'd22, 4'h2, 0, 0, 0, 0);
      check("bp_ready_low", in_ready, 1'b0);
      for (int i = 0; i < 5; i++) step(1, 32'd33, 4'h2, 0, 0, 0, 0);
      check("bp_hold_11", out_result, 32'd11);
      step(1, 32'd33, 4'h2, 0, 0, 1, 0);
      check("bp_pop_22", out_result, 32'd22);
      step(1, 32'd33, 4'h2, 0, 0, 1, 0);
      check("bp_pop_33", out_result, 32'd33);
      step(0, 0, 0, 0, 0, 1, 0);
      check("bp_empty", out_valid, 1'b0);

      // Streaming: one result per cycle, in_ready never drops
      for (int i = 0; i < 100; i++) begin
         step(1, $urandom, 4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 1, 0);
         check("stream_ready", in_ready, 1'b1);
      end
      step(0, 0, 0, 0, 0, 1, 0);

      // Random handshakes on both sides
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom), ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom,
              4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom_range(0, 7) == 0));
      end

      // Async reset while full: outputs clear before any clock edge
      step(0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 1, 0);
      step(1, 32'hA5A5_0000, 4'h1, 1, 1, 0, 0);
      step(1, 32'hFFFF_FFFF, 4'h0, 1, 1, 0, 0);
      check("pre_rst_full", in_ready, 1'b0);
      #3;
      rst = 1'b1;
      #1;
      check("arst_valid", out_valid, 1'b0);
      check("arst_ready", in_ready, 1'b1);
      check("arst_result", out_result, 0);
      check("arst_flags", {out_sel, out_zero, out_neg, out_carry, out_ovf}, 0);
      q.delete();
      exp_ready = 1'b1;
      exp_sticky = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      step(0, 0, 0, 0, 0, 1, 0);

`ifdef ALU_RESULT_STAGE_STICKY_OVF_EN
      step(1, 32'h1, 4'h1, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 1, 0);
      check("sticky_set", ovf_sticky, 1'b1);
      step(1, 32'h2, 4'h3, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1, 0);
      check("sticky_keep", ovf_sticky, 1'b1);
      step(0, 0, 0, 0, 0, 0, 1);
      check("sticky_clr", ovf_sticky, 1'b0);
      step(1, 32'h3, 4'h0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 1, 1);
      check("sticky_set_wins", ovf_sticky, 1'b1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered output stage directly downstream of the ALU's per-bit 16:1 function-select muxes.
- Captures the selected WIDTH-bit result and the 4-bit function select that produced it, and derives status flags.
- Presents everything through a 2-entry valid/ready skid buffer, so the write-back or branch logic can stall the ALU without losing a result.

Parameters:
WIDTH, 32, data width of result path
ADD_CODE, 4'h0, select code treated as arithmetic add
SUB_CODE, 4'h1, select code treated as arithmetic subtract

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
in_valid  input  1  ALU result on in_result is valid
in_ready  output  1  stage can accept a result this cycle
in_result  input  WIDTH  result bits from the function-select mux bank
in_sel  input  4  function select driven to the mux bank for this result
in_carry  input  1  adder carry-out
in_ovf  input  1  adder signed overflow
out_valid  output  1  out_* fields hold a valid entry
out_ready  input  1  consumer accepts the entry this cycle
out_result  output  WIDTH  registered result
out_sel  output  4  registered function select
out_zero  output  1  out_result == 0
out_neg  output  1  out_result[WIDTH-1]
out_carry  output  1  carry, arithmetic ops only
out_ovf  output  1  overflow, arithmetic ops only

Behaviour:
- Clocking and reset: one clock (clk). Reset (rst) is asynchronous and active-high.
- Reset values: state EMPTY, out_valid=0, in_ready=1, all out_* data/flag outputs 0, skid entry cleared. Inputs are ignored while rst=1.
- Handshake:
  - Accept occurs when in_valid & in_ready at a rising edge.
  - Pop occurs when out_valid & out_ready.
  - in_valid may assert regardless of in_ready.
  - in_result, in_sel, in_carry and in_ovf are sampled only on accept.
- Flag computation at capture (not at output):
  - zero = ~|in_result.
  - neg = in_result[WIDTH-1].
  - carry/ovf = in_carry/in_ovf when in_sel is ADD_CODE or SUB_CODE, else 0.
- Storage: main entry drives out_*; skid entry holds one extra result. Both entries store {result, sel, zero, neg, carry, ovf}.
- FSM (occupancy):
  - EMPTY:
    - accept -> ONE; main loaded.
  - ONE:
    - accept & ~pop -> TWO; skid loaded.
    - accept & pop -> ONE; main reloaded with the new input.
    - pop & ~accept -> EMPTY.
    - neither -> hold.
  - TWO:
    - pop -> ONE; main <= skid. No accept is possible, because in_ready=0.
    - no pop -> hold.
- Output and ready signals:
  - out_valid = (state != EMPTY).
  - in_ready is registered, equal to (next_state != TWO). It deasserts the cycle after the second entry lands.
- Latency and throughput:
  - Latency: accepted input appears on out_* the following cycle.
  - Throughput: 1 result/cycle with out_ready held high.
- Ordering: strict FIFO; entries are never dropped or duplicated.
- Output stability: out_* are stable while out_valid=1 and out_ready=0.
- Boundaries:
  - Full (TWO) with out_ready=0 holds indefinitely, in_ready=0.
  - Pop from EMPTY: no-op.
  - rst asserted mid-transfer discards both entries immediately (asynchronous), with no partial output.

Optional Feature:
- Macro: ALU_RESULT_STAGE_STICKY_OVF_EN.
- Defined:
  - Adds input ovf_clr (1 bit) and output ovf_sticky (1 bit), reset 0.
  - ovf_sticky sets on any pop whose entry has ovf=1.
  - ovf_clr clears it.
  - Same-cycle set and clear: set wins.
- Undefined: neither port exists and no sticky logic is built.

Test Plan:
- Reset, then single accept in_result=32'h0000_0000, in_sel=4'h0, in_carry=1, in_ovf=0 -> next cycle out_valid=1, out_zero=1, out_neg=0, out_carry=1, out_ovf=0.
- in_sel=4'h5, in_result=32'h8000_0001, in_carry=1, in_ovf=1 -> out_neg=1, out_zero=0, out_carry=0, out_ovf=0 (non-arithmetic masking).
- out_ready=0, push results 11, 22, 33 back-to-back -> in_ready drops after 22 is captured, 33 is held upstream; release out_ready -> pops 11, 22, 33 in order, none lost.
- out_ready=1 continuously, 100 random results -> one output per cycle, 1-cycle latency, in_ready never deasserts.
- State TWO, assert rst mid-cycle -> out_valid=0, in_ready=1 and all out_* =0 immediately, without waiting for a clock edge.
- With ALU_RESULT_STAGE_STICKY_OVF_EN defined: pop an entry with in_sel=4'h1, in_ovf=1 -> ovf_sticky=1 and remains 1 across later pops; ovf_clr pulse -> 0; ovf_clr coinciding with an overflow pop -> stays 1.
